// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared debounce defaults and counter sizing helper
package debounce_pkg;

    localparam int DEFAULT_WAIT_CLK    = 10;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Counter must hold values 0..wait_clk-1 plus headroom used by callers.
    function automatic int cnt_width(input int wait_clk);
        return $clog2(wait_clk + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - single debounce channel: stability counter, level and edge pulses
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   WAIT_CLK = DEFAULT_WAIT_CLK,
    parameter int   CNT_W    = cnt_width(WAIT_CLK),
    parameter logic INIT_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_d_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CLK - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s_i == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // WAIT_CLK consecutive differing samples: take the new level.
            level_d = s_i;
            cnt_d   = '0;
            rise_d  = s_i;
            fall_d  = ~s_i;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= INIT_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign evt_d_o = rise_d | fall_d;

endmodule

// File: rtl/debounce_filter_multi.sv
// rtl/debounce_filter_multi.sv - N-channel synchronised debouncer with edge pulses and aggregate event
module debounce_filter_multi
    import debounce_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              WAIT_CLK    = DEFAULT_WAIT_CLK,
    parameter int              SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic [N_CH-1:0] INIT_VAL    = {N_CH{1'b0}},
    parameter int              CNT_W       = cnt_width(WAIT_CLK)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sig,
    output logic [N_CH-1:0] debc_sig,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_evt
);

    logic [N_CH-1:0] s_w;
    logic [N_CH-1:0] evt_d_w;
    logic            any_evt_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {SYNC_STAGES{INIT_VAL[i]}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig[i]};
            end
        end

        assign s_w[i] = sync_q[SYNC_STAGES-1];

        debounce_ch #(
            .WAIT_CLK (WAIT_CLK),
            .CNT_W    (CNT_W),
            .INIT_VAL (INIT_VAL[i])
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .s_i     (s_w[i]),
            .level_o (debc_sig[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i]),
            .evt_d_o (evt_d_w[i])
        );
    end

    // Registered from the channels' next-state pulses so it lines up with rise/fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_evt_q <= 1'b0;
        end else begin
            any_evt_q <= |evt_d_w;
        end
    end

    assign any_evt = any_evt_q;

endmodule

// File: tb/tb_debounce_filter_multi.sv
// tb/tb_debounce_filter_multi.sv - randomized and directed bench for debounce_filter_multi
module tb_debounce_filter_multi;

    localparam int         SYNC   = 2;
    localparam int         WAIT_A = 10;
    localparam logic [3:0] INIT_A = 4'b1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sig   = INIT_A;
    logic [0:0] sig_m = 1'b0;

    logic [3:0] debc_a, rise_a, fall_a;
    logic       any_a;
    logic [0:0] debc_m, rise_m, fall_m;
    logic       any_m;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int rise0_cyc = -1, fall0_cyc = -1, rise_m_cyc = -1;
    int evt0_cnt  = 0,  any_cnt   = 0;
    int press;

    debounce_filter_multi #(
        .N_CH(4), .WAIT_CLK(WAIT_A), .SYNC_STAGES(SYNC), .INIT_VAL(INIT_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .sig(sig), .debc_sig(debc_a),
        .rise(rise_a), .fall(fall_a), .any_evt(any_a)
    );

    debounce_filter_multi #(
        .N_CH(1), .WAIT_CLK(1), .SYNC_STAGES(SYNC), .INIT_VAL(1'b0)
    ) dut_m (
        .clk(clk), .rst_n(rst_n), .sig(sig_m), .debc_sig(debc_m),
        .rise(rise_m), .fall(fall_m), .any_evt(any_m)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: hist[k] is the raw input captured k edges ago; the synchronised value seen
    // at this edge is hist[SYNC]. A channel flips when the last wc synchronised samples all
    // differ from its current level.
    logic [3:0] hist_a [16];
    logic [3:0] hist_m [16];
    logic [3:0] lvl_a, lvl_m, er_a, ef_a, er_m, ef_m;

    task automatic qualify(input int nch, input int wc, input logic [3:0] h [16],
                           inout logic [3:0] lvl, output logic [3:0] r, output logic [3:0] f);
        bit steady;
        r = '0;
        f = '0;
        for (int i = 0; i < nch; i++) begin
            steady = 1'b1;
            for (int k = 0; k < wc; k++)
                if (h[SYNC+k][i] == lvl[i]) steady = 1'b0;
            if (steady) begin
                r[i]   = ~lvl[i];
                f[i]   = lvl[i];
                lvl[i] = ~lvl[i];
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            hist_a[k] = INIT_A;
            hist_m[k] = 4'b0;
        end
        lvl_a = INIT_A; lvl_m = 4'b0;
        er_a = 0; ef_a = 0; er_m = 0; ef_m = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                for (int k = 0; k < 16; k++) begin
                    hist_a[k] = INIT_A;
                    hist_m[k] = 4'b0;
                end
                lvl_a = INIT_A; lvl_m = 4'b0;
                er_a = 0; ef_a = 0; er_m = 0; ef_m = 0;
            end else begin
                for (int k = 15; k > 0; k--) begin
                    hist_a[k] = hist_a[k-1];
                    hist_m[k] = hist_m[k-1];
                end
                hist_a[0] = sig;
                hist_m[0] = {3'b0, sig_m};
                qualify(4, WAIT_A, hist_a, lvl_a, er_a, ef_a);
                qualify(1, 1, hist_m, lvl_m, er_m, ef_m);
            end
            #1;
            check("a_debc", {28'b0, debc_a}, {28'b0, lvl_a});
            check("a_rise", {28'b0, rise_a}, {28'b0, er_a});
            check("a_fall", {28'b0, fall_a}, {28'b0, ef_a});
            check("a_any",  {31'b0, any_a},  {31'b0, |(er_a | ef_a)});
            check("m_debc", {31'b0, debc_m}, {31'b0, lvl_m[0]});
            check("m_rise", {31'b0, rise_m}, {31'b0, er_m[0]});
            check("m_fall", {31'b0, fall_m}, {31'b0, ef_m[0]});
            check("m_any",  {31'b0, any_m},  {31'b0, er_m[0] | ef_m[0]});
            if (rise_a[0]) rise0_cyc = cyc;
            if (fall_a[0]) fall0_cyc = cyc;
            if (rise_a[0] | fall_a[0]) evt0_cnt++;
            if (any_a) any_cnt++;
            if (rise_m[0]) rise_m_cyc = cyc;
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Min config step: one-cycle acceptance after the synchroniser.
        sig_m = 1'b1;
        press = cyc + 1;
        repeat (6) @(negedge clk);
        check("min_rise_latency", rise_m_cyc - press, 2);
        sig_m = 1'b0;

        // Bounce on channel 0 must be rejected.
        evt0_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            sig[0] = ~sig[0];
            repeat (2) @(negedge clk);
        end
        sig[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_evt0", evt0_cnt, 0);

        // Clean press and release.
        sig[0] = 1'b1;
        press = cyc + 1;
        repeat (60) @(negedge clk);
        check("rise_latency", rise0_cyc - press, 11);
        sig[0] = 1'b0;
        press = cyc + 1;
        repeat (60) @(negedge clk);
        check("fall_latency", fall0_cyc - press, 11);

        // Threshold: 9 stable samples rejected, 10 accepted then released.
        evt0_cnt = 0;
        sig[0] = 1'b1;
        repeat (9) @(negedge clk);
        sig[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("pulse9_evt0", evt0_cnt, 0);
        sig[0] = 1'b1;
        repeat (10) @(negedge clk);
        sig[0] = 1'b0;
        repeat (25) @(negedge clk);
        check("pulse10_evt0", evt0_cnt, 2);

        // Simultaneous rise on ch1 and fall on ch3.
        any_cnt = 0;
        sig[1] = 1'b1;
        sig[3] = 1'b0;
        repeat (30) @(negedge clk);
        check("indep_any_cycles", any_cnt, 1);

        // Reset in the middle of a qualification.
        sig[2] = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        // Random toggling with occasional resets.
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 9) == 0) sig[c] = ~sig[c];
            if ($urandom_range(0, 2) == 0) sig_m = ~sig_m;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
